// File: rtl/enc_ctrl_pkg.sv
// Shared constants and helpers for the enc_3 controller: default sizes, Q4.12 constants,
// the config address map and the FIFO pointer-width function.
package enc_ctrl_pkg;

  localparam int unsigned DEF_BITSIZE    = 16;
  localparam int unsigned DEF_N_IN       = 1;
  localparam int unsigned DEF_N_OUT      = 6;
  localparam int unsigned DEF_LAT        = 5;
  localparam int unsigned DEF_FIFO_DEPTH = 8;

  // Q4.12 fixed point
  localparam logic [15:0] ONE  = 16'h1000;
  localparam logic [15:0] HALF = 16'h0800;

  // Config word map: weights first, then biases
  localparam int unsigned W_BASE = 0;
  localparam int unsigned B_BASE = DEF_N_IN * DEF_N_OUT;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/enc_out_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the head entry while !empty.
module enc_out_fifo
  import enc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_BITSIZE,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push ? bump(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? bump(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

  no_overflow: assert property (@(posedge clk) disable iff (!reset)
    (push && !pop) |-> (count_q != CW'(DEPTH)));
  no_underflow: assert property (@(posedge clk) disable iff (!reset) pop |-> !empty);

endmodule

// File: rtl/enc_3_ctrl.sv
// Config, credit-based issue and result capture around the enc_3 matrix-vector datapath.
module enc_3_ctrl
  import enc_ctrl_pkg::*;
#(
  parameter int unsigned BITSIZE    = DEF_BITSIZE,
  parameter int unsigned N_IN       = DEF_N_IN,
  parameter int unsigned N_OUT      = DEF_N_OUT,
  parameter int unsigned LAT        = DEF_LAT,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cfg_we,
  input  logic [$clog2(N_IN*N_OUT+N_OUT)-1:0]  cfg_addr,
  input  logic [BITSIZE-1:0]                   cfg_data,
  output logic                                 cfg_ready,
  output logic                                 cfg_err,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [BITSIZE*N_IN-1:0]              in_x,
  output logic [BITSIZE*N_IN-1:0]              dp_x,
  output logic [BITSIZE*N_IN*N_OUT-1:0]        dp_w,
  output logic [BITSIZE*N_OUT-1:0]             dp_b,
  input  logic [BITSIZE*N_OUT-1:0]             dp_y,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [BITSIZE*N_OUT-1:0]             out_y,
  output logic                                 busy
);

  localparam int unsigned N_W   = N_IN * N_OUT;
  localparam int unsigned N_TOT = N_W + N_OUT;
  localparam int unsigned AW    = $clog2(N_TOT);
  localparam int unsigned IFW   = $clog2(LAT + 1);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW    = $clog2(FIFO_DEPTH + LAT + 1) + 1;

  logic [BITSIZE*N_TOT-1:0] cfg_q;
  logic [BITSIZE*N_IN-1:0]  x_q;
  logic [LAT-1:0]           tag_q, tag_d;
  logic [IFW-1:0]           inflight_q, inflight_d;
  logic                     cfg_err_q;

  logic          accept, push, pop;
  logic          addr_ok, cfg_wr, cfg_drop;
  logic [SW-1:0] credit_used;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;

  always_comb begin
    pop     = !fifo_empty && out_ready;
    push    = tag_q[LAT-1];
    addr_ok = (32'(cfg_addr) < N_TOT);

    cfg_ready = reset && (inflight_q == '0);
    cfg_wr    = cfg_we && cfg_ready && addr_ok;
    cfg_drop  = cfg_we && !(cfg_ready && addr_ok);

    // Slots reserved = queued + in flight; a same-cycle pop hands its slot back immediately
    credit_used = SW'(fifo_count) + SW'(inflight_q) - SW'(pop);
    in_ready    = reset && !cfg_we && (credit_used < SW'(FIFO_DEPTH));
    accept      = in_valid && in_ready;

    tag_d    = tag_q << 1;
    tag_d[0] = accept;

    inflight_d = inflight_q;
    if (accept && !push) begin
      inflight_d = inflight_q + IFW'(1);
    end else if (push && !accept) begin
      inflight_d = inflight_q - IFW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cfg_q      <= '0;
      x_q        <= '0;
      tag_q      <= '0;
      inflight_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_TOT; i++) begin
        if (cfg_wr && (cfg_addr == AW'(i))) begin
          cfg_q[BITSIZE*i +: BITSIZE] <= cfg_data;
        end
      end
      if (cfg_drop) begin
        cfg_err_q <= 1'b1;
      end
      if (accept) begin
        x_q <= in_x;
      end
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  enc_out_fifo #(
    .WIDTH (BITSIZE * N_OUT),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (dp_y),
    .dout  (out_y),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign dp_x      = x_q;
  assign dp_w      = cfg_q[BITSIZE*(W_BASE+N_W)-1 : BITSIZE*W_BASE];
  assign dp_b      = cfg_q[BITSIZE*N_TOT-1 : BITSIZE*N_W];
  assign cfg_err   = cfg_err_q;
  assign out_valid = !fifo_empty;
  assign busy      = (inflight_q != '0) || !fifo_empty;

  inflight_tracks_tags: assert property (@(posedge clk) disable iff (!reset)
    32'(inflight_q) == $countones(tag_q));

endmodule

// File: tb/tb_enc_3_ctrl.sv
// Bench for enc_3_ctrl: directed scenarios plus random traffic, all checked every cycle
// against a queue-based reference model; a behavioural datapath stub closes the loop.
module tb_enc_3_ctrl;
  import enc_ctrl_pkg::*;

  localparam int unsigned BITSIZE    = 16;
  localparam int unsigned N_IN       = 1;
  localparam int unsigned N_OUT      = 6;
  localparam int unsigned LAT        = 5;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned N_W        = N_IN * N_OUT;
  localparam int unsigned N_TOT      = N_W + N_OUT;
  localparam int unsigned AW         = $clog2(N_TOT);
  localparam int unsigned XW         = BITSIZE * N_IN;
  localparam int unsigned WW         = BITSIZE * N_W;
  localparam int unsigned YW         = BITSIZE * N_OUT;

  logic          clk;
  logic          reset;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [BITSIZE-1:0] cfg_data;
  logic          cfg_ready, cfg_err;
  logic          in_valid, in_ready;
  logic [XW-1:0] in_x, dp_x;
  logic [WW-1:0] dp_w;
  logic [YW-1:0] dp_b, dp_y, out_y;
  logic          out_valid, out_ready, busy;

  enc_3_ctrl #(
    .BITSIZE    (BITSIZE),
    .N_IN       (N_IN),
    .N_OUT      (N_OUT),
    .LAT        (LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .dp_x      (dp_x),
    .dp_w      (dp_w),
    .dp_b      (dp_b),
    .dp_y      (dp_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt  = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // y_j = b_j + sum_i W[j*N_IN+i] * x_i, Q4.12, wrapped to BITSIZE
  function automatic logic [YW-1:0] mac(input logic [XW-1:0] x, input logic [WW-1:0] w,
                                        input logic [YW-1:0] b);
    logic [YW-1:0] y;
    int acc;
    for (int j = 0; j < N_OUT; j++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++) begin
        acc += int'($signed(w[(j*N_IN+i)*BITSIZE +: BITSIZE])) *
               int'($signed(x[i*BITSIZE +: BITSIZE]));
      end
      y[j*BITSIZE +: BITSIZE] = BITSIZE'((acc >>> 12) + int'($signed(b[j*BITSIZE +: BITSIZE])));
    end
    return y;
  endfunction

  // Datapath stub: LAT-1 register stages after the combinational MAC of the dp_* registers
  logic [YW-1:0] dp_pipe [LAT-1];
  always @(posedge clk) begin
    dp_pipe[0] <= mac(dp_x, dp_w, dp_b);
    for (int s = 1; s < LAT - 1; s++) dp_pipe[s] <= dp_pipe[s-1];
  end
  assign dp_y = dp_pipe[LAT-2];

  // Reference model: state after the most recent edge, advanced once per negedge
  logic [YW-1:0]          fifo_m[$];
  logic [YW-1:0]          pend_m[$];
  int                     due_m[$];
  logic [BITSIZE*N_TOT-1:0] shadow = '0;
  logic                   err_m = 1'b0;
  logic [XW-1:0]          x_m = '0;
  int                     cyc = 0;
  bit                     mon_on = 1'b0;
  logic                   pop_e, irdy_e;

  always @(negedge clk) begin
    if (mon_on) begin
      pop_e  = reset && (fifo_m.size() != 0) && out_ready;
      irdy_e = reset && !cfg_we &&
               (fifo_m.size() + pend_m.size() - int'(pop_e) < int'(FIFO_DEPTH));
      check_eq("out_valid", out_valid, fifo_m.size() != 0);
      if (fifo_m.size() != 0) check_eq("out_y", out_y, fifo_m[0]);
      check_eq("busy", busy, (fifo_m.size() + pend_m.size()) != 0);
      check_eq("in_ready", in_ready, irdy_e);
      check_eq("cfg_ready", cfg_ready, reset && (pend_m.size() == 0));
      check_eq("cfg_err", cfg_err, err_m);
      check_eq("dp_w", dp_w, shadow[WW-1:0]);
      check_eq("dp_b", dp_b, shadow[BITSIZE*N_TOT-1:WW]);
      check_eq("dp_x", dp_x, x_m);

      cyc++;
      if (!reset) begin
        fifo_m.delete();
        pend_m.delete();
        due_m.delete();
        shadow = '0;
        err_m  = 1'b0;
        x_m    = '0;
      end else begin
        if (cfg_we) begin
          if (pend_m.size() == 0 && int'(cfg_addr) < int'(N_TOT))
            shadow[int'(cfg_addr)*BITSIZE +: BITSIZE] = cfg_data;
          else
            err_m = 1'b1;
        end
        if (pop_e) void'(fifo_m.pop_front());
        if (pend_m.size() != 0 && due_m[0] == cyc) begin
          fifo_m.push_back(pend_m.pop_front());
          void'(due_m.pop_front());
        end
        if (in_valid && irdy_e) begin
          pend_m.push_back(mac(in_x, shadow[WW-1:0], shadow[BITSIZE*N_TOT-1:WW]));
          due_m.push_back(cyc + LAT);
          x_m = in_x;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input logic [BITSIZE-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_data = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [XW-1:0] x);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_x     = x;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    if (done) begin
      @(posedge clk);
      #1;
      acc_cnt++;
    end
    check_eq("send_accepted", done, 1'b1);
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;
    tick(1);
    reset = 1'b1;

    // Single vector: latency and 1.0*0.5 + 0.25 on every lane
    for (int i = 0; i < N_W; i++) cfg_write(i, ONE);
    for (int j = 0; j < N_OUT; j++) cfg_write(B_BASE + j, 16'h0400);
    out_ready = 1'b1;
    send(HALF);
    repeat (LAT - 1) @(posedge clk);
    #1;
    check_eq("t1_valid_early", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check_eq("t1_valid", out_valid, 1'b1);
    check_eq("t1_out_y", out_y, {N_OUT{16'h0C00}});
    tick(10);
    check_eq("t1_busy", busy, 1'b0);

    // Backpressure: 10 back-to-back, only FIFO_DEPTH accepted until out_ready rises
    out_ready = 1'b0;
    acc_cnt   = 0;
    fork
      for (int k = 1; k <= 10; k++) send(XW'(k * 256));
      begin
        tick(20);
        check_eq("t2_accepts", acc_cnt, FIFO_DEPTH);
        check_eq("t2_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
      end
    join
    tick(20);
    check_eq("t2_total", acc_cnt, 10);

    // Config while busy is dropped
    send(16'h0400);
    cfg_write(0, 16'h2000);
    check_eq("t3_cfg_err", cfg_err, 1'b1);
    tick(10);

    // Config/input collision: write wins, input follows with new weight
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = HALF;
    in_valid = 1'b1; in_x = ONE;
    @(negedge clk);
    check_eq("t4_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    send(ONE);
    tick(10);

    // Reset with 3 in flight and 2 queued
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(XW'(16'h0300 + k));
    tick(2);
    reset = 1'b0;
    tick(1);
    check_eq("t5_out_valid", out_valid, 1'b0);
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_dp_w", dp_w, '0);
    check_eq("t5_dp_b", dp_b, '0);
    reset = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      tick(1);
      check_eq("t5_no_stale", out_valid, 1'b0);
    end

    // Out-of-range address leaves W/b untouched
    for (int i = 0; i < N_TOT; i++) cfg_write(i, BITSIZE'($urandom));
    cfg_write(N_TOT, 16'hFFFF);
    check_eq("t6_cfg_err", cfg_err, 1'b1);
    tick(2);

    // Random traffic, occasional resets
    for (int c = 0; c < 800; c++) begin
      reset     = ($urandom_range(0, 199) != 0);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_addr  = AW'($urandom_range(0, 15));
      cfg_data  = BITSIZE'($urandom);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_x      = XW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    reset = 1'b1; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(30);
    check_eq("drain_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/enc_3_ctrl.md
# enc_3_ctrl

Sequencer and configuration controller for the single-layer fixed-point matrix-vector datapath (`enc_3`: y = W·x + b, BITSIZE-bit words). It holds the layer's weight and bias registers, loaded through a word-wide config port. It issues input vectors into the fully pipelined datapath under credit control and tracks in-flight results. Results are captured into an output FIFO with valid/ready backpressure. It sits between the encoder's input stream and the next encoder stage.

## Interface
- BITSIZE, 16, word width; fixed-point Q4.12, where 0x1000 = 1.0
- N_IN, 1, input vector length
- N_OUT, 6, output vector length
- LAT, 5, datapath latency in cycles from dp_x register update to a valid dp_y
- FIFO_DEPTH, 8, output FIFO entries; must be ≥ 1
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- cfg_we  in  1  config word write strobe
- cfg_addr  in  $clog2(N_IN*N_OUT+N_OUT)  word address: 0..N_IN*N_OUT-1 = W word i; next N_OUT = b word j
- cfg_data  in  BITSIZE  config word
- cfg_ready  out  1  config writes accepted (no results in flight)
- cfg_err  out  1  sticky: a write was dropped or out of range
- in_valid / in_ready  in / out  1  input vector handshake
- in_x  in  BITSIZE*N_IN  input vector, flattened, element 0 in LSBs
- dp_x, dp_w, dp_b  out  BITSIZE*N_IN, BITSIZE*N_IN*N_OUT, BITSIZE*N_OUT  registered datapath operands
- dp_y  in  BITSIZE*N_OUT  datapath result
- out_valid / out_ready  out / in  1  result handshake
- out_y  out  BITSIZE*N_OUT  head-of-FIFO result
- busy  out  1  results in flight or FIFO non-empty

## Operation
- **Config write.** When cfg_we && cfg_ready, the addressed word is written into the W/b register (word i at bits [BITSIZE*i +: BITSIZE]). dp_w and dp_b are driven directly from these registers.
- **Dropped writes.** A write with cfg_ready=0, or with cfg_addr ≥ N_IN*N_OUT+N_OUT, is dropped. cfg_err is set and stays set until reset.
- **cfg_ready** = (inflight == 0). A weight change can never corrupt an issued vector.
- **Credits.** in_ready = (fifo_count + inflight < FIFO_DEPTH) && !cfg_we. Config has priority over input in the same cycle.
- **Issue.** On an accept (in_valid && in_ready), dp_x ← in_x, and a 1 is shifted into the LAT-bit tag shift register; otherwise a 0 is shifted in. inflight counts the tags that are set.
- **Capture.** When the tag leaving the shift register is 1, dp_y is pushed into the FIFO. Because of credits the push never overflows, so no full check is needed on push.
- **Output.** The FIFO is show-ahead: out_valid = !empty, out_y = head. A pop occurs on out_valid && out_ready.
- **Simultaneous push and pop.** fifo_count is unchanged; both the pointers advance.
- **Ordering.** Results leave strictly in issue order.
- No arithmetic is done in this block. Widths pass through unchanged.

## Timing
- **Reset values (cycle after reset=0 sampled):**
  - W, b, and dp_x are all zero.
  - The tag shift register is zero; inflight = 0.
  - The FIFO is empty, so out_valid = 0.
  - busy = 0, cfg_err = 0.
- **Outputs while reset is held low:** in_ready = 0 and cfg_ready = 0. Both are 1 on the first cycle after release.
- **Latency.** If accepted on edge t, the result is pushed on edge t+LAT, and out_valid is high in the cycle following edge t+LAT.
- **Throughput.** One vector per cycle while credits remain and out_ready = 1.
- **Full.** With out_ready held 0, exactly FIFO_DEPTH vectors are accepted, then in_ready = 0.
- **Credit return.** A pop frees a credit in the same cycle's in_ready, because in_ready is combinational from the registered count and the pop.
- **Reset mid-operation.** In-flight tags and FIFO contents are discarded. No stale result ever appears after reset.
- **Config latency.** A config write takes effect on dp_w/dp_b the cycle after the write edge.

## Structure
- **Package `enc_ctrl_pkg`:**
  - default BITSIZE, and the Q4.12 constants ONE = 16'h1000;
  - the config address-map localparams (W_BASE = 0, B_BASE = N_IN*N_OUT);
  - the FIFO pointer-width function.
- **Sub-module `enc_out_fifo`:** a synchronous show-ahead FIFO with parameters WIDTH and DEPTH, ports push/pop/count/empty, and the same synchronous active-low reset.
- **Top level:** the controller, containing the tag shift register, the inflight counter, the credit logic, and the config decode.

## Test plan
1. **Single vector.** Release reset; write W words 0..5 = 0x1000 and b words 6..11 = 0x0400; send x = 0x0800 with out_ready=1. Expect out_valid exactly LAT cycles after the accept and all six out_y lanes = 0x0C00. busy then returns to 0.
2. **Backpressure.** Send 10 back-to-back vectors (x = 0x0100·k) with out_ready=0. Expect in_ready to drop after 8 accepts. Then raise out_ready and expect 8 results in order, then the remaining 2, with no loss.
3. **Config while busy.** Write W0 = 0x2000 one cycle after an accept. Expect cfg_ready=0, cfg_err=1, and the result still computed with W0 = 0x1000.
4. **Config/input collision.** With the controller idle, assert cfg_we and in_valid together. Expect the write applied and in_ready=0 that cycle; the input is accepted next cycle and uses the new value.
5. **Reset mid-flight.** Pull reset low with 3 vectors in flight and 2 queued. Expect out_valid=0, busy=0, and W/b = 0 next cycle, and no output appears for LAT+2 cycles.
6. **Out-of-range address.** Write cfg_addr = 12 with data 0xFFFF. Expect cfg_err=1 and all W/b words unchanged.
